// File: rtl/data_mem_lsu.sv
// Load/store sequencer in front of a 64x8 combinational-read data memory.
// Optional address bounds checking is enabled by defining LSU_BOUNDS_CHECK_EN.
module data_mem_lsu #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  txn_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_depth_check
        $error("data_mem_lsu: DEPTH must lie in 1 .. 2**ADDR_W");
    end

    state_t              r_state;
    logic                r_op_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_mem_we;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic [CNT_W-1:0]    r_txn_count;
    logic                w_addr_err;

`ifdef LSU_BOUNDS_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} >= DEPTH_L);
    endfunction

    assign w_addr_err = addr_out_of_range(req_addr);
`else
    assign w_addr_err = 1'b0;
`endif

    // mem_we is its own flop so the store strobe is a clean single-cycle pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op_we     <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_txn_count <= '0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op_we <= req_we;
                        if (w_addr_err) begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= S_RESP;
                        end else begin
                            r_mem_addr  <= req_addr;
                            r_mem_wdata <= req_wdata;
                            r_mem_we    <= req_we;
                            r_rsp_err   <= 1'b0;
                            r_state     <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    r_rsp_rdata <= r_op_we ? '0 : mem_rdata;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_txn_count <= r_txn_count + CNT_ONE;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign txn_count = r_txn_count;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu with a behavioural 64x8 memory attached.
module tb_data_mem_lsu;

`ifdef LSU_BOUNDS_CHECK_EN
    localparam int TB_DEPTH = 32;
`else
    localparam int TB_DEPTH = 64;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_we;
    logic [5:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [7:0] rsp_rdata;
    logic [5:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic       mem_we;
    logic [15:0] txn_count;

    logic [7:0] mem     [64];
    logic [7:0] exp_mem [64];
    logic [8:0] sb_q [$];
    int n_chk = 0;
    int n_err = 0;
    int exp_cnt = 0;
    int we_cycles = 0;

    data_mem_lsu #(.ADDR_W(6), .DATA_W(8), .DEPTH(TB_DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic oob(input logic [5:0] a);
`ifdef LSU_BOUNDS_CHECK_EN
        return (int'(a) >= TB_DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    // response monitor: handshake completes at the next rising edge
    always @(negedge clk) begin
        if (mem_we) we_cycles++;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_rsp", 1, 0);
            end else begin
                logic [8:0] e;
                e = sb_q.pop_front();
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[8]});
                chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e[7:0]});
                exp_cnt++;
            end
        end
    end

    task automatic txn(input logic we, input logic [5:0] a, input logic [7:0] d, input int hold);
        logic       err;
        logic [7:0] exp_rd;
        logic [5:0] prev_addr;
        logic [5:0] exp_addr;
        int n, w0;
        err = oob(a);
        prev_addr = mem_addr;
        exp_addr = err ? prev_addr : a;
        w0 = we_cycles;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk("req_ready_wait", {31'd0, req_ready}, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_rd = (we || err) ? 8'h00 : exp_mem[a];
        if (we && !err) exp_mem[a] = d;
        sb_q.push_back({err, exp_rd});
        rsp_ready = (hold == 0);
        if (err) begin
            chk("oob_mem_we", {31'd0, mem_we}, 0);
            chk("oob_addr", {26'd0, mem_addr}, {26'd0, prev_addr});
            chk("oob_rsp_valid_n1", {31'd0, rsp_valid}, 1);
        end else begin
            chk("acc_rsp_valid", {31'd0, rsp_valid}, 0);
            chk("acc_mem_we", {31'd0, mem_we}, {31'd0, we});
            chk("acc_addr", {26'd0, mem_addr}, {26'd0, a});
            if (we) chk("acc_wdata", {24'd0, mem_wdata}, {24'd0, d});
            @(posedge clk); #1;
            chk("resp_mem_we", {31'd0, mem_we}, 0);
            chk("rsp_valid_n2", {31'd0, rsp_valid}, 1);
        end
        if (hold > 0) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = a ^ 6'h01; req_wdata = ~d;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk("hold_valid", {31'd0, rsp_valid}, 1);
                chk("hold_rdata", {24'd0, rsp_rdata}, {24'd0, exp_rd});
                chk("hold_req_ready", {31'd0, req_ready}, 0);
            end
            req_valid = 1'b0;
            chk("hold_addr", {26'd0, mem_addr}, {26'd0, exp_addr});
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("txn_count", {16'd0, txn_count}, exp_cnt);
        chk("post_req_ready", {31'd0, req_ready}, 1);
        chk("we_pulses", we_cycles - w0, (we && !err) ? 1 : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin mem[i] = 8'h00; exp_mem[i] = 8'h00; end
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_req_ready", {31'd0, req_ready}, 1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_mem_we", {31'd0, mem_we}, 0);
        chk("rst_mem_addr", {26'd0, mem_addr}, 0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 0);
        chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 0);
        chk("rst_txn_count", {16'd0, txn_count}, 0);

        txn(1'b1, 6'h05, 8'hA5, 0);
        txn(1'b0, 6'h05, 8'h00, 0);
        txn(1'b0, 6'h05, 8'h00, 5);
        txn(1'b1, 6'h1F, 8'h3C, 5);

        for (int k = 0; k < 16; k++)
            txn($urandom_range(0, 1) == 1, 6'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 2));

`ifdef LSU_BOUNDS_CHECK_EN
        txn(1'b1, 6'h3F, 8'h77, 0);
        txn(1'b0, 6'h20, 8'h00, 3);
        txn(1'b0, 6'h1F, 8'h00, 0);
`endif

        // reset while a store is in ACCESS
        req_valid = 1'b1; req_we = 1'b1; req_addr = 6'h0A; req_wdata = 8'h5C;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rstacc_mem_we_before", {31'd0, mem_we}, 1);
        rst_n = 1'b0;
        exp_mem[6'h0A] = 8'h5C;
        @(posedge clk); #1;
        exp_cnt = 0;
        chk("rstacc_mem_we", {31'd0, mem_we}, 0);
        chk("rstacc_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rstacc_txn_count", {16'd0, txn_count}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstacc_no_rsp", {31'd0, rsp_valid}, 0);
        chk("rstacc_mem_we_after", {31'd0, mem_we}, 0);

        txn(1'b0, 6'h0A, 8'h00, 0);
        txn(1'b0, 6'h05, 8'h00, 1);
        chk("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
